// File: rtl/sysbus_interconnect_if.sv
// Core-side system bus bundle for sysbus_interconnect.
// Request:  system_bus_en, system_bus_rdwr (1 = write), system_bus_mask,
//           system_bus_addr, system_bus_wr_data
// Response: system_bus_rd_data, system_bus_rd_valid, system_bus_stall,
//           system_bus_err
// master: the core data port.  slave: the interconnect.
interface sysbus_interconnect_if;
    logic        system_bus_en;
    logic        system_bus_rdwr;
    logic [3:0]  system_bus_mask;
    logic [31:0] system_bus_addr;
    logic [31:0] system_bus_wr_data;
    logic [31:0] system_bus_rd_data;
    logic        system_bus_rd_valid;
    logic        system_bus_stall;
    logic        system_bus_err;

    modport master (
        output system_bus_en, system_bus_rdwr, system_bus_mask,
               system_bus_addr, system_bus_wr_data,
        input  system_bus_rd_data, system_bus_rd_valid, system_bus_stall,
               system_bus_err
    );

    modport slave (
        input  system_bus_en, system_bus_rdwr, system_bus_mask,
               system_bus_addr, system_bus_wr_data,
        output system_bus_rd_data, system_bus_rd_valid, system_bus_stall,
               system_bus_err
    );
endinterface

// File: rtl/sysbus_interconnect.sv
// System-bus interconnect: decodes addr[31:28] to a one-hot slave enable,
// tracks outstanding reads to slaves of differing fixed latency so data
// returns in order, stalls the core on would-be collisions/reordering, and
// handles unmapped accesses (error response or default slave) with first-error
// capture.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   bus           - core-side bus (sysbus_interconnect_if.slave)
//   slv_en        - one-hot slave enable (asserted on acceptance)
//   slv_rdwr, slv_mask, slv_wr_data, slv_addr - broadcast to all slaves
//   slv_rd_data   - packed read data, slave i at [32*i +: 32]
//   err_sticky, err_addr - first-error capture; err_clr clears the sticky
module sysbus_interconnect #(
    parameter int unsigned          NUM_SLV     = 4,
    parameter logic [NUM_SLV*4-1:0] SLV_REGION  = {4'h9, 4'h8, 4'h1, 4'h0},
    parameter logic [NUM_SLV*2-1:0] SLV_LAT     = {2'd1, 2'd1, 2'd1, 2'd1},
    parameter bit                   ERR_EN      = 1'b1,
    parameter int unsigned          DEFAULT_SLV = 0,
    parameter bit                   REG_OUT     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    sysbus_interconnect_if.slave    bus,
    output logic [NUM_SLV-1:0]      slv_en,
    output logic                    slv_rdwr,
    output logic [3:0]              slv_mask,
    output logic [31:0]             slv_wr_data,
    output logic [31:0]             slv_addr,
    input  logic [NUM_SLV*32-1:0]   slv_rd_data,
    output logic                    err_sticky,
    output logic [31:0]             err_addr,
    input  logic                    err_clr
);
    localparam int          IW       = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] sel_idx;
    logic          unmapped_err;
    logic [1:0]    req_lat;
    logic          ahead_busy;
    logic          stall;
    logic          accept;
    logic          rd_push;
    logic          wr_err;
    logic          err_event;

    // Return tracker; slot 1 is the one returning this cycle.
    logic [3:1]    slot_v;
    logic [3:1]    slot_err;
    logic [IW-1:0] slot_idx [1:3];

    logic          ret_v;
    logic          ret_err;
    logic [31:0]   ret_data;

    logic          out_v;
    logic          out_err;
    logic [31:0]   out_data;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (bus.system_bus_addr[31:28] == SLV_REGION[4*i +: 4]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign sel_idx      = hit ? hit_idx : IW'(DEFAULT_SLV);
    assign unmapped_err = ~hit & ERR_EN;
    assign req_lat      = unmapped_err ? 2'd1 : SLV_LAT[2*int'(sel_idx) +: 2];

    // A read with latency L may not land on or behind an entry that, after
    // this cycle's shift, sits in slot L or higher.
    always_comb begin
        case (req_lat)
            2'd1:    ahead_busy = slot_v[2] | slot_v[3];
            2'd2:    ahead_busy = slot_v[3];
            default: ahead_busy = 1'b0;
        endcase
    end

    assign stall     = ~rst & bus.system_bus_en & ~bus.system_bus_rdwr & ahead_busy;
    assign accept    = ~rst & bus.system_bus_en & ~stall;
    assign rd_push   = accept & ~bus.system_bus_rdwr;
    assign wr_err    = accept & bus.system_bus_rdwr & unmapped_err;
    assign err_event = accept & unmapped_err;

    always_comb begin
        slv_en = '0;
        if (accept && !unmapped_err) begin
            slv_en[sel_idx] = 1'b1;
        end
    end

    assign slv_rdwr    = bus.system_bus_rdwr;
    assign slv_mask    = bus.system_bus_mask;
    assign slv_wr_data = bus.system_bus_wr_data;
    assign slv_addr    = {bus.system_bus_addr[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v   <= '0;
            slot_err <= '0;
            for (int k = 1; k <= 3; k++) begin
                slot_idx[k] <= '0;
            end
        end else begin
            slot_v      <= {1'b0, slot_v[3:2]};
            slot_err    <= {1'b0, slot_err[3:2]};
            slot_idx[1] <= slot_idx[2];
            slot_idx[2] <= slot_idx[3];
            slot_idx[3] <= '0;
            if (rd_push) begin
                case (req_lat)
                    2'd3: begin
                        slot_v[3]   <= 1'b1;
                        slot_err[3] <= unmapped_err;
                        slot_idx[3] <= sel_idx;
                    end
                    2'd2: begin
                        slot_v[2]   <= 1'b1;
                        slot_err[2] <= unmapped_err;
                        slot_idx[2] <= sel_idx;
                    end
                    default: begin
                        slot_v[1]   <= 1'b1;
                        slot_err[1] <= unmapped_err;
                        slot_idx[1] <= sel_idx;
                    end
                endcase
            end
        end
    end

    // A clear in the same cycle as a new error re-arms capture of the new address.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_addr   <= '0;
        end else if (err_event) begin
            if (!err_sticky || err_clr) begin
                err_addr <= bus.system_bus_addr;
            end
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

    assign ret_v    = slot_v[1];
    assign ret_err  = slot_err[1];
    assign ret_data = !ret_v  ? 32'h0 :
                      ret_err ? ERR_DATA :
                                slv_rd_data[32*int'(slot_idx[1]) +: 32];

    generate
        if (REG_OUT) begin : g_reg_out
            logic        v_q;
            logic        err_q;
            logic [31:0] data_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q    <= 1'b0;
                    err_q  <= 1'b0;
                    data_q <= '0;
                end else begin
                    v_q    <= ret_v;
                    err_q  <= ret_v & ret_err;
                    data_q <= ret_data;
                end
            end
            assign out_v    = v_q;
            assign out_err  = err_q;
            assign out_data = data_q;
        end else begin : g_comb_out
            assign out_v    = ret_v;
            assign out_err  = ret_v & ret_err;
            assign out_data = ret_data;
        end
    endgenerate

    // Outputs read as reset values for the whole reset cycle, not only after it.
    assign bus.system_bus_rd_valid = out_v & ~rst;
    assign bus.system_bus_rd_data  = rst ? 32'h0 : out_data;
    assign bus.system_bus_err      = ((out_err & ~rst) | wr_err);
    assign bus.system_bus_stall    = stall;
endmodule
